// File: rtl/way_fill_demux.sv
// way_fill_demux: collects a cache-line refill arriving in beats into a line
// buffer, then writes the full line into one of 4 ways with a one-hot,
// single-cycle write enable. Every output comes from a register or is decoded
// from state, so no input reaches an output in the same cycle.
module way_fill_demux #(
   parameter int LINE_SIZE_BYTES = 64,
   parameter int BEAT_BYTES      = 8    // LINE_SIZE_BYTES/BEAT_BYTES must be an integer >= 2
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_fill_start,
   input  logic [3:0]                   i_way_sel,
   input  logic                         i_abort,
   input  logic                         i_beat_valid,
   output logic                         o_beat_ready,
   input  logic [BEAT_BYTES*8-1:0]      i_beat_data,
   output logic [3:0]                   o_way_we,
   output logic [LINE_SIZE_BYTES*8-1:0] o_line_data,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_sel_err
);

   localparam int BEATS  = LINE_SIZE_BYTES / BEAT_BYTES;
   localparam int BEAT_W = BEAT_BYTES * 8;
   localparam int CNT_W  = (BEATS > 2) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

   state_t                        state;
   logic [CNT_W-1:0]              count;
   logic [3:0]                    sel_q;
   logic                          sel_err_q;
   logic [BEATS-1:0][BEAT_W-1:0]  line_q;

   logic sel_onehot;
   logic beat_acc;
   logic last_beat;

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
   assign sel_onehot = (i_way_sel != 4'b0000) && ((i_way_sel & (i_way_sel - 4'd1)) == 4'b0000);
   // Abort wins over a beat presented in the same cycle.
   assign beat_acc   = (state == COLLECT) && i_beat_valid && !i_abort;
   assign last_beat  = (count == CNT_W'(BEATS - 1));

   // Control FSM: target latch, beat counter, select-error pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         count     <= '0;
         sel_q     <= '0;
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (i_fill_start) begin
                  if (sel_onehot) begin
                     sel_q <= i_way_sel;
                     count <= '0;
                     state <= COLLECT;
                  end else begin
                     sel_err_q <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (i_abort) begin
                  count <= '0;
                  state <= IDLE;
               end else if (beat_acc) begin
                  if (last_beat) begin
                     count <= '0;
                     state <= WRITE;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
            end
            WRITE:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Line buffer: one slice per beat, loaded when its beat index is accepted.
   for (genvar b = 0; b < BEATS; b++) begin : g_slice
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n)
            line_q[b] <= '0;
         else if (beat_acc && (count == CNT_W'(b)))
            line_q[b] <= i_beat_data;
      end
   end

   assign o_beat_ready = (state == COLLECT);
   assign o_busy       = (state != IDLE);
   assign o_done       = (state == WRITE);
   assign o_way_we     = (state == WRITE) ? sel_q : 4'b0000;
   assign o_sel_err    = sel_err_q;
   assign o_line_data  = line_q;

endmodule

// File: tb/tb_way_fill_demux.sv
// Directed bench for way_fill_demux: reset, normal/stalled fills, bad select,
// abort, and async reset mid-collect.
module tb_way_fill_demux;

   localparam int BEATS = 8;

   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b0;
   logic         i_fill_start = 1'b0;
   logic [3:0]   i_way_sel = '0;
   logic         i_abort = 1'b0;
   logic         i_beat_valid = 1'b0;
   logic         o_beat_ready;
   logic [63:0]  i_beat_data = '0;
   logic [3:0]   o_way_we;
   logic [511:0] o_line_data;
   logic         o_busy;
   logic         o_done;
   logic         o_sel_err;

   int checks = 0;
   int failures = 0;

   way_fill_demux #(.LINE_SIZE_BYTES(64), .BEAT_BYTES(8)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_fill_start(i_fill_start),
      .i_way_sel(i_way_sel), .i_abort(i_abort), .i_beat_valid(i_beat_valid),
      .o_beat_ready(o_beat_ready), .i_beat_data(i_beat_data),
      .o_way_we(o_way_we), .o_line_data(o_line_data), .o_busy(o_busy),
      .o_done(o_done), .o_sel_err(o_sel_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Full fill with optional stall of stall_n cycles before beat stall_at.
   // A stray start with a different one-hot sel is injected during beat 3.
   task automatic do_fill(input string tag, input logic [3:0] sel, input logic [63:0] base,
                          input int stall_at, input int stall_n);
      logic [511:0] exp_line;
      exp_line = '0;
      i_fill_start = 1'b1;
      i_way_sel    = sel;
      step();
      i_fill_start = 1'b0;
      i_way_sel    = '0;
      chk({tag, " ready_c1"}, o_beat_ready, 1'b1);
      chk({tag, " busy_c1"}, o_busy, 1'b1);
      for (int k = 0; k < BEATS; k++) begin
         if (k == stall_at) begin
            i_beat_valid = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               step();
               chk({tag, " stall_we"}, o_way_we, 4'b0000);
               chk({tag, " stall_ready"}, o_beat_ready, 1'b1);
            end
         end
         chk({tag, " we_collect"}, o_way_we, 4'b0000);
         i_beat_valid = 1'b1;
         i_beat_data  = base + 64'(k);
         exp_line[64*k +: 64] = base + 64'(k);
         if (k == 3) begin
            i_fill_start = 1'b1;
            i_way_sel    = (sel == 4'b1000) ? 4'b0001 : 4'b1000;
         end
         step();
         i_fill_start = 1'b0;
         i_way_sel    = '0;
      end
      i_beat_valid = 1'b0;
      chk({tag, " way_we"}, o_way_we, sel);
      chk({tag, " done"}, o_done, 1'b1);
      chk({tag, " ready_wr"}, o_beat_ready, 1'b0);
      chk({tag, " line"}, o_line_data, exp_line);
      step();
      chk({tag, " done_once"}, o_done, 1'b0);
      chk({tag, " we_after"}, o_way_we, 4'b0000);
      chk({tag, " busy_after"}, o_busy, 1'b0);
      chk({tag, " line_hold"}, o_line_data, exp_line);
   endtask

   task automatic bad_sel(input string tag, input logic [3:0] sel);
      i_fill_start = 1'b1;
      i_way_sel    = sel;
      step();
      i_fill_start = 1'b0;
      i_way_sel    = '0;
      chk({tag, " sel_err"}, o_sel_err, 1'b1);
      chk({tag, " busy"}, o_busy, 1'b0);
      chk({tag, " we"}, o_way_we, 4'b0000);
      step();
      chk({tag, " sel_err_pulse"}, o_sel_err, 1'b0);
      chk({tag, " busy2"}, o_busy, 1'b0);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst we", o_way_we, 4'b0000);
      chk("rst line", o_line_data, '0);
      chk("rst busy", o_busy, 1'b0);
      chk("rst done", o_done, 1'b0);
      chk("rst ready", o_beat_ready, 1'b0);
      chk("rst sel_err", o_sel_err, 1'b0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      step();
      chk("idle ready", o_beat_ready, 1'b0);
      chk("idle busy", o_busy, 1'b0);

      // Basic and stalled fills
      do_fill("basic", 4'b0100, 64'h0, -1, 0);
      do_fill("stall", 4'b0001, 64'hA0, 3, 3);

      // Bad selects
      bad_sel("bad0110", 4'b0110);
      bad_sel("bad0000", 4'b0000);

      // Abort after 4 beats, with a beat presented alongside the abort
      i_fill_start = 1'b1;
      i_way_sel    = 4'b1000;
      step();
      i_fill_start = 1'b0;
      i_way_sel    = '0;
      for (int k = 0; k < 4; k++) begin
         i_beat_valid = 1'b1;
         i_beat_data  = 64'hDEAD_0000 + 64'(k);
         step();
      end
      i_abort     = 1'b1;
      i_beat_data = 64'hBAD;
      step();
      i_abort      = 1'b0;
      i_beat_valid = 1'b0;
      chk("abort busy", o_busy, 1'b0);
      chk("abort ready", o_beat_ready, 1'b0);
      chk("abort we", o_way_we, 4'b0000);
      step();
      chk("abort we2", o_way_we, 4'b0000);
      chk("abort done", o_done, 1'b0);
      do_fill("postabort", 4'b0010, 64'h100, -1, 0);

      // Async reset after 6 beats
      i_fill_start = 1'b1;
      i_way_sel    = 4'b0001;
      step();
      i_fill_start = 1'b0;
      i_way_sel    = '0;
      for (int k = 0; k < 6; k++) begin
         i_beat_valid = 1'b1;
         i_beat_data  = 64'h5500 + 64'(k);
         step();
      end
      i_beat_valid = 1'b0;
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("arst busy", o_busy, 1'b0);
      chk("arst ready", o_beat_ready, 1'b0);
      chk("arst line", o_line_data, '0);
      chk("arst we", o_way_we, 4'b0000);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      step();
      chk("arst idle", o_busy, 1'b0);
      do_fill("postrst", 4'b0100, 64'h200, -1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
